// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes handshaked bitstream words MSB-first onto ccff_head.
// Define CCFF_LOADER_VERIFY_EN to compile the CRC-based recirculating readback check.
module ccff_chain_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 56,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_ok
);

  localparam int unsigned LW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
`ifdef CCFF_LOADER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [LW-1:0]     left_q;
  logic [CNT_W-1:0]  sent_q;
  logic              word_ready_q;
  logic              head_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  remain_d;
  logic [CNT_W-1:0]  sent_inc_d;
  logic [LW-1:0]     nbits_d;

  always_comb begin
    remain_d   = CNT_W'(CHAIN_LEN) - sent_q;
    sent_inc_d = sent_q + CNT_W'(1);
    nbits_d    = LW'(WORD_W);
    if (32'(remain_d) < WORD_W) nbits_d = LW'(remain_d);
  end

`ifdef CCFF_LOADER_VERIFY_EN
  logic [15:0]      crc_a_q;
  logic [15:0]      crc_b_q;
  logic [CNT_W-1:0] vcnt_q;
  logic             verify_ok_q;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      left_q       <= '0;
      sent_q       <= '0;
      word_ready_q <= 1'b0;
      head_q       <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
      crc_a_q      <= '1;
      crc_b_q      <= '1;
      vcnt_q       <= '0;
      verify_ok_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sent_q       <= '0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_a_q      <= '1;
            crc_b_q      <= '1;
            verify_ok_q  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            head_q       <= word_data[WORD_W-1];
            shreg_q      <= word_data << 1;
            left_q       <= nbits_d;
            en_q         <= 1'b1;
            word_ready_q <= 1'b0;
            state_q      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sent_q <= sent_inc_d;
`ifdef CCFF_LOADER_VERIFY_EN
          crc_a_q <= crc_step(crc_a_q, head_q);
`endif
          if (left_q > LW'(1)) begin
            head_q  <= shreg_q[WORD_W-1];
            shreg_q <= shreg_q << 1;
            left_q  <= left_q - LW'(1);
          end else if (sent_inc_d != CNT_W'(CHAIN_LEN)) begin
            head_q       <= 1'b0;
            en_q         <= 1'b0;
            word_ready_q <= 1'b1;
            state_q      <= S_LOAD;
          end else begin
            head_q <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
            // Chain keeps shifting straight into recirculation; head is muxed to the tail.
            vcnt_q  <= '0;
            state_q <= S_VERIFY;
`else
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end
        end
`ifdef CCFF_LOADER_VERIFY_EN
        S_VERIFY: begin
          crc_b_q <= crc_step(crc_b_q, ccff_tail);
          vcnt_q  <= vcnt_q + CNT_W'(1);
          if (vcnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            verify_ok_q <= (crc_a_q == crc_step(crc_b_q, ccff_tail));
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign word_ready   = word_ready_q;
  assign chain_clk_en = en_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef CCFF_LOADER_VERIFY_EN
  // Recirculation must be a direct tail-to-head path; a register here would rotate the chain by one.
  assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
  assign verify_ok = verify_ok_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign verify_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed scoreboard bench for ccff_chain_loader with behavioural chain models (56- and 13-bit).
module tb_ccff_chain_loader;

`ifdef CCFF_LOADER_VERIFY_EN
  localparam int LAT56 = 119;
  localparam int LAT13 = 28;
  localparam int EN56  = 112;
  localparam int EN13  = 26;
`else
  localparam int LAT56 = 63;
  localparam int LAT13 = 15;
  localparam int EN56  = 56;
  localparam int EN13  = 13;
`endif

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  logic       start = 1'b0, word_valid = 1'b0;
  logic [7:0] word_data = '0;
  logic       word_ready, ccff_head, chain_clk_en, ccff_tail, busy, done, verify_ok;

  logic       s13 = 1'b0, wv13 = 1'b0;
  logic [7:0] wd13 = '0;
  logic       ready13, head13, en13, tail13, busy13, done13, vok13;

  ccff_chain_loader u_dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
    .chain_clk_en(chain_clk_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .verify_ok(verify_ok)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(13)) u_dut13 (
    .prog_clk(prog_clk), .pReset(pReset), .start(s13), .word_data(wd13),
    .word_valid(wv13), .word_ready(ready13), .ccff_head(head13),
    .chain_clk_en(en13), .ccff_tail(tail13), .busy(busy13), .done(done13),
    .verify_ok(vok13)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = c << 1;
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  // Behavioural chains; stage 20 of the long chain can be stuck at 0.
  logic [55:0] chain56 = '0;
  logic [12:0] chain13 = '0;
  bit          stuck = 1'b0;
  assign ccff_tail = chain56[55];
  assign tail13    = chain13[12];

  always @(posedge prog_clk) begin
    logic [55:0] nxt;
    if (chain_clk_en) begin
      nxt = {chain56[54:0], ccff_head};
      if (stuck) nxt[20] = 1'b0;
      chain56 <= nxt;
    end
    if (en13) chain13 <= {chain13[11:0], head13};
  end

  logic        sbq[$];
  logic        sbq13[$];
  int          en_cnt = 0, en13_cnt = 0;
  logic [15:0] crc_a_m = '1, crc_b_m = '1;

  always @(negedge prog_clk) begin
    if (!pReset) begin
      if (chain_clk_en) begin
        en_cnt++;
        if (sbq.size() > 0) chk("head_bit", ccff_head, sbq.pop_front());
        else begin
          crc_b_m = crc16(crc_b_m, ccff_tail);
          chk("recirc", ccff_head, ccff_tail);
        end
      end else chk("head_idle0", ccff_head, 1'b0);
      if (en13) begin
        en13_cnt++;
        if (sbq13.size() > 0) chk("head13_bit", head13, sbq13.pop_front());
        else chk("recirc13", head13, tail13);
      end
    end
  end

  logic [7:0] words56 [7] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h55};

  task automatic tick();
    @(posedge prog_clk); #1;
  endtask

  task automatic load56(input int gap_at, input int gap_len, input bit noise,
                        input int abort_at, output int cyc);
    int idx = 0, gap = 0, sent = 0, shifts = 0, t = 0, n;
    bit aborted = 1'b0;
    en_cnt = 0; crc_a_m = '1; crc_b_m = '1;
    start = 1'b1; word_valid = 1'b0;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && t < 600) begin
      word_valid = 1'b0;
      start = noise && (busy === 1'b1);
      if (word_ready === 1'b1 && idx < 7) begin
        if (idx == gap_at && gap < gap_len) begin
          gap++;
          chk("gap_en", chain_clk_en, 1'b0);
        end else begin
          word_valid = 1'b1;
          word_data  = words56[idx];
          n = (56 - sent < 8) ? 56 - sent : 8;
          for (int b = 0; b < n; b++) begin
            sbq.push_back(word_data[7-b]);
            crc_a_m = crc16(crc_a_m, word_data[7-b]);
          end
          sent += n;
          idx++;
        end
      end else if (noise) begin
        word_valid = 1'b1;
        word_data  = 8'($urandom);
      end
      tick();
      t++;
      if (chain_clk_en === 1'b1) shifts++;
      if (abort_at > 0 && shifts == abort_at) begin
        pReset = 1'b1; word_valid = 1'b0; start = 1'b0;
        tick();
        chk("abort_ready", word_ready, 1'b0);
        chk("abort_head", ccff_head, 1'b0);
        chk("abort_en", chain_clk_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_vok", verify_ok, 1'b0);
        pReset = 1'b0;
        sbq.delete();
        aborted = 1'b1;
        break;
      end
    end
    word_valid = 1'b0; start = 1'b0;
    cyc = t;
    if (!aborted) begin
      chk("done_seen", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      tick();
      chk("done_pulse_1cyc", done, 1'b0);
      chk("busy_after_done", busy, 1'b0);
    end
  endtask

  initial begin
    int cyc;
    int t;
    int idx, sent, n;
    logic [7:0] w13 [2] = '{8'hF0, 8'hAB};

    pReset = 1'b1;
    tick(); tick();
    chk("rst_ready", word_ready, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_en", chain_clk_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_vok", verify_ok, 1'b0);
    pReset = 1'b0;
    tick();
    chk("idle_ready", word_ready, 1'b0);

    // Basic load
    load56(-1, 0, 1'b0, 0, cyc);
    chk("basic_latency", cyc, LAT56);
    chk("basic_en_pulses", en_cnt, EN56);
    chk("basic_chain", chain56, 56'hA53CFF00817E55);
`ifdef CCFF_LOADER_VERIFY_EN
    chk("basic_vok_model", verify_ok, crc_a_m == crc_b_m);
    chk("basic_vok", verify_ok, 1'b1);
`else
    chk("basic_vok_tied0", verify_ok, 1'b0);
`endif

    // Backpressure before the third word
    chain56 = '0;
    load56(2, 5, 1'b0, 0, cyc);
    chk("bp_latency", cyc, LAT56 + 5);
    chk("bp_en_pulses", en_cnt, EN56);
    chk("bp_chain", chain56, 56'hA53CFF00817E55);

    // Reset at the 20th shift cycle, then reload from bit 0
    chain56 = '0;
    load56(-1, 0, 1'b0, 20, cyc);
    tick();
    chk("post_abort_idle_en", chain_clk_en, 1'b0);
    load56(-1, 0, 1'b0, 0, cyc);
    chk("reload_latency", cyc, LAT56);
    chk("reload_chain", chain56, 56'hA53CFF00817E55);

    // start and word_valid noise while busy
    chain56 = '0;
    load56(-1, 0, 1'b1, 0, cyc);
    chk("noise_latency", cyc, LAT56);
    chk("noise_en_pulses", en_cnt, EN56);
    chk("noise_chain", chain56, 56'hA53CFF00817E55);
    tick(); tick();
    chk("noise_no_restart_busy", busy, 1'b0);
    chk("noise_no_restart_ready", word_ready, 1'b0);

    // Partial final word on the 13-bit chain
    en13_cnt = 0;
    s13 = 1'b1; tick(); s13 = 1'b0;
    t = 0; idx = 0; sent = 0;
    while (done13 !== 1'b1 && t < 200) begin
      wv13 = 1'b0;
      if (ready13 === 1'b1 && idx < 2) begin
        wv13 = 1'b1;
        wd13 = w13[idx];
        n = (13 - sent < 8) ? 13 - sent : 8;
        for (int b = 0; b < n; b++) sbq13.push_back(wd13[7-b]);
        sent += n;
        idx++;
      end
      tick();
      t++;
    end
    wv13 = 1'b0;
    chk("p13_done", done13, 1'b1);
    chk("p13_latency", t, LAT13);
    chk("p13_en_pulses", en13_cnt, EN13);
    chk("p13_chain", chain13, 13'h1E15);
`ifdef CCFF_LOADER_VERIFY_EN
    chk("p13_vok", vok13, 1'b1);
`else
    chk("p13_vok_tied0", vok13, 1'b0);
`endif
    tick();

`ifdef CCFF_LOADER_VERIFY_EN
    // Stuck-at-0 stage in the chain must be caught by readback
    stuck = 1'b1;
    load56(-1, 0, 1'b0, 0, cyc);
    chk("stuck_latency", cyc, LAT56);
    chk("stuck_vok_model", verify_ok, crc_a_m == crc_b_m);
    chk("stuck_vok", verify_ok, 1'b0);
    stuck = 1'b0;
    tick();
    chk("stuck_vok_held", verify_ok, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
